// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter.
//   mem_size_e  : access width forwarded to the memory macro
//   owner_e     : which pipeline port owns the outstanding access
//   arb_state_e : arbiter FSM states
// Also holds the latency counter width and a helper that computes the
// counter reload value for a given memory latency.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_e;

    // Memory latency is limited to 1..4, so the counter only ever holds 0..3.
    localparam int LAT_W = 2;

    // The counter is loaded on issue and reaches zero on the response cycle.
    function automatic logic [LAT_W-1:0] latReload(input int lat);
        return LAT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the arbiter, the IF/MEM pipeline stages and the memory.
//   if_*   : instruction-fetch request/grant/response
//   dm_*   : data-memory request/grant/response
//   mem_*  : issue channel to the memory macro, plus its read data
//   busy   : a transaction is outstanding
// Modport slave is the arbiter's view; master is the surrounding system.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    import mem_pkg::*;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    mem_size_e         dm_size;
    logic              dm_unsigned;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_en;
    logic              mem_we;
    mem_size_e         mem_size;
    logic              mem_unsigned;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_size, dm_unsigned, dm_addr, dm_wdata,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_en, mem_we, mem_size, mem_unsigned, mem_addr, mem_wdata,
        output busy
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_size, dm_unsigned, dm_addr, dm_wdata,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_en, mem_we, mem_size, mem_unsigned, mem_addr, mem_wdata,
        input  busy
    );

endinterface

// File: rtl/mem_port_arbiter_starve_prio_arb.sv
// Two-input fixed-priority arbiter with a fetch starvation counter.
// Data wins by default; once STARVE_MAX data grants have been made in a row
// while a fetch was waiting, the fetch wins the next arbitration.
//   clk, rst     : clock, synchronous active-high reset
//   if_req_i     : fetch port requesting
//   dm_req_i     : data port requesting
//   grant_en_i   : the arbiter is allowed to grant this cycle
//   if_win_o     : fetch would win this cycle
//   dm_win_o     : data would win this cycle
module starve_prio_arb
    import mem_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req_i,
    input  logic dm_req_i,
    input  logic grant_en_i,
    output logic if_win_o,
    output logic dm_win_o
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             starveHit;

    // Winner selection: a waiting fetch overrides data only once starved.
    assign starveHit = (starve_cnt_q == CNT_W'(STARVE_MAX));
    assign if_win_o  = if_req_i && (!dm_req_i || starveHit);
    assign dm_win_o  = dm_req_i && !if_win_o;

    // The counter only measures back-to-back data grants that bypassed a
    // waiting fetch; it forgets as soon as the fetch is served or withdrawn.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!if_req_i) begin
            starve_cnt_d = '0;
        end else if (grant_en_i && if_win_o) begin
            starve_cnt_d = '0;
        end else if (grant_en_i && dm_win_o && !starveHit) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the instruction-fetch and data ports.
// One access is outstanding at a time; the memory answers MEM_LAT cycles after
// issue and the response is routed back to whichever port was granted.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave view of mem_port_arbiter_if (IF, DM and memory channels)
// Parameters: ADDR_W, DATA_W bus widths; MEM_LAT memory latency (1..4);
// STARVE_MAX consecutive data grants tolerated while a fetch waits.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);

    arb_state_e       state_q, state_d;
    owner_e           owner_q, owner_d;
    logic             store_q, store_d;
    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;

    logic rspCycle;
    logic grantEn;
    logic ifWin;
    logic dmWin;
    logic ifGnt;
    logic dmGnt;
    logic rspValid;

    // The response cycle of the outstanding access doubles as a grant slot,
    // so back-to-back accesses need no idle cycle in between. Reset blocks
    // everything so no output moves while rst is high.
    assign rspCycle = (state_q == ARB_WAIT) && (lat_cnt_q == '0);
    assign grantEn  = !rst && ((state_q == ARB_IDLE) || rspCycle);
    assign rspValid = !rst && rspCycle;

    starve_prio_arb #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk        (clk),
        .rst        (rst),
        .if_req_i   (bus.if_req),
        .dm_req_i   (bus.dm_req),
        .grant_en_i (grantEn),
        .if_win_o   (ifWin),
        .dm_win_o   (dmWin)
    );

    assign ifGnt = grantEn && ifWin;
    assign dmGnt = grantEn && dmWin;

    // State register: FSM state, owner of the outstanding access, whether it
    // was a store, and the latency countdown.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            owner_q   <= OWN_IF;
            store_q   <= 1'b0;
            lat_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            store_q   <= store_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    // Next-state logic: a grant always (re)starts the countdown; otherwise
    // WAIT counts down and falls back to IDLE after the response cycle.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        store_d   = store_q;
        lat_cnt_d = lat_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (ifGnt || dmGnt) begin
                    state_d   = ARB_WAIT;
                    owner_d   = dmGnt ? OWN_DM : OWN_IF;
                    store_d   = dmGnt && bus.dm_we;
                    lat_cnt_d = latReload(MEM_LAT);
                end
            end
            ARB_WAIT: begin
                if (lat_cnt_q != '0) begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end else if (ifGnt || dmGnt) begin
                    owner_d   = dmGnt ? OWN_DM : OWN_IF;
                    store_d   = dmGnt && bus.dm_we;
                    lat_cnt_d = latReload(MEM_LAT);
                end else begin
                    state_d   = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Output logic: grants and the memory issue channel come straight from
    // the request mux; the response is steered to the latched owner. Store
    // acks return zero data rather than whatever the memory drives.
    always_comb begin
        bus.if_gnt       = ifGnt;
        bus.dm_gnt       = dmGnt;
        bus.mem_en       = ifGnt || dmGnt;
        bus.mem_we       = 1'b0;
        bus.mem_size     = MEM_WORD;
        bus.mem_unsigned = 1'b0;
        bus.mem_addr     = {ADDR_W{1'b0}};
        bus.mem_wdata    = {DATA_W{1'b0}};
        if (dmGnt) begin
            bus.mem_we       = bus.dm_we;
            bus.mem_size     = bus.dm_size;
            bus.mem_unsigned = bus.dm_unsigned;
            bus.mem_addr     = bus.dm_addr;
            bus.mem_wdata    = bus.dm_wdata;
        end else if (ifGnt) begin
            bus.mem_addr     = bus.if_addr;
        end

        bus.if_rvalid = rspValid && (owner_q == OWN_IF);
        bus.dm_rvalid = rspValid && (owner_q == OWN_DM);
        bus.if_rdata  = {DATA_W{1'b0}};
        bus.dm_rdata  = {DATA_W{1'b0}};
        if (bus.if_rvalid) begin
            bus.if_rdata = bus.mem_rdata;
        end
        if (bus.dm_rvalid && !store_q) begin
            bus.dm_rdata = bus.mem_rdata;
        end

        bus.busy = !rst && (state_q == ARB_WAIT);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Two instances: dut1 with a
// one-cycle memory and dut3 with a three-cycle memory, each with its own
// behavioural memory model. dut1 runs a per-cycle vector table; dut3 runs
// hand-written store/load and mid-transaction reset sequences.
module tb_mem_port_arbiter;
    import mem_pkg::*;

    localparam int LAT1 = 1;
    localparam int LAT3 = 3;
    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT1), .STARVE_MAX(SMAX))
        dut1 (.clk(clk), .rst(rst), .bus(b1));
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT3), .STARVE_MAX(SMAX))
        dut3 (.clk(clk), .rst(rst), .bus(b3));

    // Memory contents after reset: address-tagged words, with 0xFF at 0x80.
    function automatic logic [31:0] initWord(input int i);
        return (i == 32) ? 32'h0000_00FF : (32'hC0DE_0000 | 32'(i * 4));
    endfunction

    function automatic logic [31:0] loadData(input logic [31:0] w, input logic [31:0] a,
                                             input mem_size_e s, input logic u);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> (8 * int'(a[1:0])));
        h = 16'(w >> (a[1] ? 16 : 0));
        case (s)
            MEM_BYTE: return u ? {24'h0, b} : {{24{b[7]}}, b};
            MEM_HALF: return u ? {16'h0, h} : {{16{h[15]}}, h};
            default:  return w;
        endcase
    endfunction

    function automatic logic [31:0] storeMerge(input logic [31:0] w, input logic [31:0] a,
                                               input mem_size_e s, input logic [31:0] d);
        logic [31:0] m;
        int          sh;
        case (s)
            MEM_BYTE: begin sh = 8 * int'(a[1:0]); m = 32'h0000_00FF << sh; end
            MEM_HALF: begin sh = a[1] ? 16 : 0;    m = 32'h0000_FFFF << sh; end
            default:  begin sh = 0;                m = 32'hFFFF_FFFF;       end
        endcase
        return (w & ~m) | ((d << sh) & m);
    endfunction

    // Memory models: write and read sampled at issue, read data delayed by
    // a LAT-deep pipeline so it appears exactly LAT cycles after mem_en.
    logic [31:0] mem1 [0:255];
    logic [31:0] pipe1 [0:LAT1-1];
    logic [31:0] mem3 [0:255];
    logic [31:0] pipe3 [0:LAT3-1];

    assign b1.mem_rdata = pipe1[LAT1-1];
    assign b3.mem_rdata = pipe3[LAT3-1];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem1[i] <= initWord(i);
        end else if (b1.mem_en && b1.mem_we) begin
            mem1[b1.mem_addr[9:2]] <= storeMerge(mem1[b1.mem_addr[9:2]], b1.mem_addr,
                                                 b1.mem_size, b1.mem_wdata);
        end
        pipe1[0] <= b1.mem_en ? loadData(mem1[b1.mem_addr[9:2]], b1.mem_addr,
                                         b1.mem_size, b1.mem_unsigned) : 32'h0;
        for (int k = 1; k < LAT1; k++) pipe1[k] <= pipe1[k-1];
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem3[i] <= initWord(i);
        end else if (b3.mem_en && b3.mem_we) begin
            mem3[b3.mem_addr[9:2]] <= storeMerge(mem3[b3.mem_addr[9:2]], b3.mem_addr,
                                                 b3.mem_size, b3.mem_wdata);
        end
        pipe3[0] <= b3.mem_en ? loadData(mem3[b3.mem_addr[9:2]], b3.mem_addr,
                                         b3.mem_size, b3.mem_unsigned) : 32'h0;
        for (int k = 1; k < LAT3; k++) pipe3[k] <= pipe3[k-1];
    end

    // Protocol guard on the bench's own stimulus: a pending request must hold
    // its payload until granted.
    bit          pendIf1 = 1'b0, pendDm1 = 1'b0, pendIf3 = 1'b0, pendDm3 = 1'b0;
    logic [31:0] pIfA1, pIfA3;
    logic [67:0] pDm1, pDm3;

    always @(posedge clk) begin
        if (!rst && pendIf1) assert (b1.if_req && b1.if_addr == pIfA1);
        if (!rst && pendDm1) assert (b1.dm_req && {b1.dm_addr, b1.dm_we, b1.dm_size,
                                     b1.dm_unsigned, b1.dm_wdata} == pDm1);
        if (!rst && pendIf3) assert (b3.if_req && b3.if_addr == pIfA3);
        if (!rst && pendDm3) assert (b3.dm_req && {b3.dm_addr, b3.dm_we, b3.dm_size,
                                     b3.dm_unsigned, b3.dm_wdata} == pDm3);
        pendIf1 <= !rst && b1.if_req && !b1.if_gnt;
        pendDm1 <= !rst && b1.dm_req && !b1.dm_gnt;
        pendIf3 <= !rst && b3.if_req && !b3.if_gnt;
        pendDm3 <= !rst && b3.dm_req && !b3.dm_gnt;
        pIfA1   <= b1.if_addr;
        pIfA3   <= b3.if_addr;
        pDm1    <= {b1.dm_addr, b1.dm_we, b1.dm_size, b1.dm_unsigned, b1.dm_wdata};
        pDm3    <= {b3.dm_addr, b3.dm_we, b3.dm_size, b3.dm_unsigned, b3.dm_wdata};
    end

    initial assert (LAT1 >= 1 && LAT1 <= 4 && LAT3 >= 1 && LAT3 <= 4);

    typedef struct {
        logic        ifReq;
        logic [31:0] ifAddr;
        logic        dmReq;
        logic        dmWe;
        mem_size_e   dmSize;
        logic        dmUns;
        logic [31:0] dmAddr;
        logic        eIfGnt;
        logic        eDmGnt;
        logic        eIfRv;
        logic [31:0] eIfRd;
        logic        eDmRv;
        logic [31:0] eDmRd;
        logic        eMemEn;
        logic [31:0] eMemAddr;
        logic        eMemWe;
        mem_size_e   eMemSize;
        logic        eMemUns;
        logic        eBusy;
        int          eStarve;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkVec(
        input logic ifReq, input logic [31:0] ifAddr, input logic dmReq, input logic dmWe,
        input mem_size_e dmSize, input logic dmUns, input logic [31:0] dmAddr,
        input logic eIfGnt, input logic eDmGnt, input logic eIfRv, input logic [31:0] eIfRd,
        input logic eDmRv, input logic [31:0] eDmRd, input logic eMemEn,
        input logic [31:0] eMemAddr, input logic eMemWe, input mem_size_e eMemSize,
        input logic eMemUns, input logic eBusy, input int eStarve);
        vec_t v;
        v.ifReq = ifReq;   v.ifAddr = ifAddr;   v.dmReq = dmReq;     v.dmWe = dmWe;
        v.dmSize = dmSize; v.dmUns = dmUns;     v.dmAddr = dmAddr;
        v.eIfGnt = eIfGnt; v.eDmGnt = eDmGnt;   v.eIfRv = eIfRv;     v.eIfRd = eIfRd;
        v.eDmRv = eDmRv;   v.eDmRd = eDmRd;     v.eMemEn = eMemEn;   v.eMemAddr = eMemAddr;
        v.eMemWe = eMemWe; v.eMemSize = eMemSize; v.eMemUns = eMemUns;
        v.eBusy = eBusy;   v.eStarve = eStarve;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs on the chosen instance at the falling edge,
    // then let the combinational outputs settle before any check.
    task automatic applyStimulus(input int which, input logic r, input logic ifReq,
                                 input logic [31:0] ifAddr, input logic dmReq, input logic dmWe,
                                 input mem_size_e dmSize, input logic dmUns,
                                 input logic [31:0] dmAddr, input logic [31:0] dmWdata);
        @(negedge clk);
        rst = r;
        if (which == 1) begin
            b1.if_req = ifReq; b1.if_addr = ifAddr; b1.dm_req = dmReq; b1.dm_we = dmWe;
            b1.dm_size = dmSize; b1.dm_unsigned = dmUns; b1.dm_addr = dmAddr;
            b1.dm_wdata = dmWdata;
        end else begin
            b3.if_req = ifReq; b3.if_addr = ifAddr; b3.dm_req = dmReq; b3.dm_we = dmWe;
            b3.dm_size = dmSize; b3.dm_unsigned = dmUns; b3.dm_addr = dmAddr;
            b3.dm_wdata = dmWdata;
        end
        #1;
    endtask

    task automatic checkDut(input int which, input string tag, input logic eIfGnt,
                            input logic eDmGnt, input logic eIfRv, input logic [31:0] eIfRd,
                            input logic eDmRv, input logic [31:0] eDmRd, input logic eMemEn,
                            input logic eBusy);
        if (which == 1) begin
            checkOutput({tag, ".ifGnt"},   32'(b1.if_gnt),    32'(eIfGnt));
            checkOutput({tag, ".dmGnt"},   32'(b1.dm_gnt),    32'(eDmGnt));
            checkOutput({tag, ".bothGnt"}, 32'(b1.if_gnt & b1.dm_gnt), 32'h0);
            checkOutput({tag, ".ifRv"},    32'(b1.if_rvalid), 32'(eIfRv));
            checkOutput({tag, ".ifRd"},    b1.if_rdata,       eIfRd);
            checkOutput({tag, ".dmRv"},    32'(b1.dm_rvalid), 32'(eDmRv));
            checkOutput({tag, ".dmRd"},    b1.dm_rdata,       eDmRd);
            checkOutput({tag, ".memEn"},   32'(b1.mem_en),    32'(eMemEn));
            checkOutput({tag, ".busy"},    32'(b1.busy),      32'(eBusy));
        end else begin
            checkOutput({tag, ".ifGnt"},   32'(b3.if_gnt),    32'(eIfGnt));
            checkOutput({tag, ".dmGnt"},   32'(b3.dm_gnt),    32'(eDmGnt));
            checkOutput({tag, ".bothGnt"}, 32'(b3.if_gnt & b3.dm_gnt), 32'h0);
            checkOutput({tag, ".ifRv"},    32'(b3.if_rvalid), 32'(eIfRv));
            checkOutput({tag, ".ifRd"},    b3.if_rdata,       eIfRd);
            checkOutput({tag, ".dmRv"},    32'(b3.dm_rvalid), 32'(eDmRv));
            checkOutput({tag, ".dmRd"},    b3.dm_rdata,       eDmRd);
            checkOutput({tag, ".memEn"},   32'(b3.mem_en),    32'(eMemEn));
            checkOutput({tag, ".busy"},    32'(b3.busy),      32'(eBusy));
        end
    endtask

    initial begin
        b1.if_req = 0; b1.if_addr = 0; b1.dm_req = 0; b1.dm_we = 0; b1.dm_size = MEM_WORD;
        b1.dm_unsigned = 0; b1.dm_addr = 0; b1.dm_wdata = 0;
        b3.if_req = 0; b3.if_addr = 0; b3.dm_req = 0; b3.dm_we = 0; b3.dm_size = MEM_WORD;
        b3.dm_unsigned = 0; b3.dm_addr = 0; b3.dm_wdata = 0;

        // IF-only fetches 0x0, 0x4, 0x8 back to back.
        vecs.push_back(mkVec(1, 32'h0, 0, 0, MEM_WORD, 0, 0,   1, 0, 0, 0,            0, 0,            1, 32'h0,   0, MEM_WORD, 0, 0, 0));
        vecs.push_back(mkVec(1, 32'h4, 0, 0, MEM_WORD, 0, 0,   1, 0, 1, 32'hC0DE0000, 0, 0,            1, 32'h4,   0, MEM_WORD, 0, 1, 0));
        vecs.push_back(mkVec(1, 32'h8, 0, 0, MEM_WORD, 0, 0,   1, 0, 1, 32'hC0DE0004, 0, 0,            1, 32'h8,   0, MEM_WORD, 0, 1, 0));
        vecs.push_back(mkVec(0, 32'h0, 0, 0, MEM_WORD, 0, 0,   0, 0, 1, 32'hC0DE0008, 0, 0,            0, 32'h0,   0, MEM_WORD, 0, 1, 0));
        vecs.push_back(mkVec(0, 32'h0, 0, 0, MEM_WORD, 0, 0,   0, 0, 0, 0,            0, 0,            0, 32'h0,   0, MEM_WORD, 0, 0, 0));
        // Simultaneous fetch 0xC and load 0x100: data first, fetch on its response.
        vecs.push_back(mkVec(1, 32'hC, 1, 0, MEM_WORD, 0, 32'h100, 0, 1, 0, 0,        0, 0,            1, 32'h100, 0, MEM_WORD, 0, 0, 0));
        vecs.push_back(mkVec(1, 32'hC, 0, 0, MEM_WORD, 0, 0,   1, 0, 0, 0,            1, 32'hC0DE0100, 1, 32'hC,   0, MEM_WORD, 0, 1, 1));
        vecs.push_back(mkVec(0, 32'h0, 0, 0, MEM_WORD, 0, 0,   0, 0, 1, 32'hC0DE000C, 0, 0,            0, 32'h0,   0, MEM_WORD, 0, 1, 0));
        vecs.push_back(mkVec(0, 32'h0, 0, 0, MEM_WORD, 0, 0,   0, 0, 0, 0,            0, 0,            0, 32'h0,   0, MEM_WORD, 0, 0, 0));
        // Starvation: data held for six accesses, fetch 0x10 waiting.
        vecs.push_back(mkVec(1, 32'h10, 1, 0, MEM_WORD, 0, 32'h104, 0, 1, 0, 0,       0, 0,            1, 32'h104, 0, MEM_WORD, 0, 0, 0));
        vecs.push_back(mkVec(1, 32'h10, 1, 0, MEM_WORD, 0, 32'h104, 0, 1, 0, 0,       1, 32'hC0DE0104, 1, 32'h104, 0, MEM_WORD, 0, 1, 1));
        vecs.push_back(mkVec(1, 32'h10, 1, 0, MEM_WORD, 0, 32'h104, 0, 1, 0, 0,       1, 32'hC0DE0104, 1, 32'h104, 0, MEM_WORD, 0, 1, 2));
        vecs.push_back(mkVec(1, 32'h10, 1, 0, MEM_WORD, 0, 32'h104, 0, 1, 0, 0,       1, 32'hC0DE0104, 1, 32'h104, 0, MEM_WORD, 0, 1, 3));
        vecs.push_back(mkVec(1, 32'h10, 1, 0, MEM_WORD, 0, 32'h104, 1, 0, 0, 0,       1, 32'hC0DE0104, 1, 32'h10,  0, MEM_WORD, 0, 1, 4));
        vecs.push_back(mkVec(0, 32'h0,  1, 0, MEM_WORD, 0, 32'h104, 0, 1, 1, 32'hC0DE0010, 0, 0,       1, 32'h104, 0, MEM_WORD, 0, 1, 0));
        vecs.push_back(mkVec(0, 32'h0, 0, 0, MEM_WORD, 0, 0,   0, 0, 0, 0,            1, 32'hC0DE0104, 0, 32'h0,   0, MEM_WORD, 0, 1, 0));
        vecs.push_back(mkVec(0, 32'h0, 0, 0, MEM_WORD, 0, 0,   0, 0, 0, 0,            0, 0,            0, 32'h0,   0, MEM_WORD, 0, 0, 0));
        // Byte loads from 0x80 (0xFF), signed then unsigned.
        vecs.push_back(mkVec(0, 32'h0, 1, 0, MEM_BYTE, 0, 32'h80, 0, 1, 0, 0,         0, 0,            1, 32'h80,  0, MEM_BYTE, 0, 0, 0));
        vecs.push_back(mkVec(0, 32'h0, 1, 0, MEM_BYTE, 1, 32'h80, 0, 1, 0, 0,         1, 32'hFFFFFFFF, 1, 32'h80,  0, MEM_BYTE, 1, 1, 0));
        vecs.push_back(mkVec(0, 32'h0, 0, 0, MEM_WORD, 0, 0,   0, 0, 0, 0,            1, 32'h000000FF, 0, 32'h0,   0, MEM_WORD, 0, 1, 0));
        vecs.push_back(mkVec(0, 32'h0, 0, 0, MEM_WORD, 0, 0,   0, 0, 0, 0,            0, 0,            0, 32'h0,   0, MEM_WORD, 0, 0, 0));

        // Reset state of both instances.
        repeat (3) @(negedge clk);
        #1;
        checkDut(1, "reset1", 0, 0, 0, 0, 0, 0, 0, 0);
        checkDut(3, "reset3", 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset1.starve", 32'(dut1.u_arb.starve_cnt_q), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven run on the one-cycle-latency instance.
        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            applyStimulus(1, 0, vecs[i].ifReq, vecs[i].ifAddr, vecs[i].dmReq, vecs[i].dmWe,
                          vecs[i].dmSize, vecs[i].dmUns, vecs[i].dmAddr, 32'h0);
            checkDut(1, tag, vecs[i].eIfGnt, vecs[i].eDmGnt, vecs[i].eIfRv, vecs[i].eIfRd,
                     vecs[i].eDmRv, vecs[i].eDmRd, vecs[i].eMemEn, vecs[i].eBusy);
            checkOutput({tag, ".starve"}, 32'(dut1.u_arb.starve_cnt_q), 32'(vecs[i].eStarve));
            if (vecs[i].eMemEn) begin
                checkOutput({tag, ".memAddr"}, b1.mem_addr,          vecs[i].eMemAddr);
                checkOutput({tag, ".memWe"},   32'(b1.mem_we),       32'(vecs[i].eMemWe));
                checkOutput({tag, ".memSize"}, 32'(b1.mem_size),     32'(vecs[i].eMemSize));
                checkOutput({tag, ".memUns"},  32'(b1.mem_unsigned), 32'(vecs[i].eMemUns));
            end
        end

        // Three-cycle latency: store 0xDEADBEEF to 0x20, then load it back.
        applyStimulus(3, 0, 0, 0, 1, 1, MEM_WORD, 0, 32'h20, 32'hDEADBEEF);
        checkDut(3, "st.issue", 0, 1, 0, 0, 0, 0, 1, 0);
        checkOutput("st.memWe",    32'(b3.mem_we), 32'h1);
        checkOutput("st.memWdata", b3.mem_wdata,   32'hDEADBEEF);
        applyStimulus(3, 0, 0, 0, 0, 0, MEM_WORD, 0, 0, 0);
        checkDut(3, "st.w1", 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(3, 0, 0, 0, 0, 0, MEM_WORD, 0, 0, 0);
        checkDut(3, "st.w2", 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(3, 0, 0, 0, 0, 0, MEM_WORD, 0, 0, 0);
        checkDut(3, "st.ack", 0, 0, 0, 0, 1, 0, 0, 1);
        applyStimulus(3, 0, 0, 0, 1, 0, MEM_WORD, 0, 32'h20, 0);
        checkDut(3, "ld.issue", 0, 1, 0, 0, 0, 0, 1, 0);
        checkOutput("ld.memWe", 32'(b3.mem_we), 32'h0);
        applyStimulus(3, 0, 0, 0, 0, 0, MEM_WORD, 0, 0, 0);
        checkDut(3, "ld.w1", 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(3, 0, 0, 0, 0, 0, MEM_WORD, 0, 0, 0);
        checkDut(3, "ld.w2", 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(3, 0, 0, 0, 0, 0, MEM_WORD, 0, 0, 0);
        checkDut(3, "ld.rsp", 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 1);
        applyStimulus(3, 0, 0, 0, 0, 0, MEM_WORD, 0, 0, 0);
        checkDut(3, "ld.idle", 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset one cycle after a load grant: the load is abandoned.
        applyStimulus(3, 0, 0, 0, 1, 0, MEM_WORD, 0, 32'h20, 0);
        checkDut(3, "rs.issue", 0, 1, 0, 0, 0, 0, 1, 0);
        applyStimulus(3, 1, 0, 0, 0, 0, MEM_WORD, 0, 0, 0);
        checkDut(3, "rs.rst1", 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(3, 1, 0, 0, 0, 0, MEM_WORD, 0, 0, 0);
        checkDut(3, "rs.rst2", 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(3, 0, 1, 32'h24, 0, 0, MEM_WORD, 0, 0, 0);
        checkDut(3, "rs.fetch", 1, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("rs.memAddr", b3.mem_addr, 32'h24);
        applyStimulus(3, 0, 0, 0, 0, 0, MEM_WORD, 0, 0, 0);
        checkDut(3, "rs.w1", 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(3, 0, 0, 0, 0, 0, MEM_WORD, 0, 0, 0);
        checkDut(3, "rs.w2", 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(3, 0, 0, 0, 0, 0, MEM_WORD, 0, 0, 0);
        checkDut(3, "rs.rsp", 0, 0, 1, 32'hC0DE0024, 0, 0, 0, 1);
        applyStimulus(3, 0, 0, 0, 0, 0, MEM_WORD, 0, 0, 0);
        checkDut(3, "rs.idle", 0, 0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
